sprite_ram_loader: RTL and testbench

- Writer-side front end for the sprite/map block RAMs. Those RAMs expose a write port (data_In, write_address, we) that is otherwise left unused.
- Accepts a framed byte stream over a valid/ready handshake from a host bridge (UART/NIOS PIO), decodes a header and writes the payload bytes into the character RAM or the map RAM.
- Enables run-time reload of sprites/maps instead of $readmemh-only initialisation.
- Sits between the host bridge and the write ports of the two RAMs. Read ports are untouched.

---
 rtl/sprite_ram_loader.sv | 137 +++++++++++++
 tb/tb_sprite_ram_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Framed byte-stream loader for the sprite/map block RAMs: decodes a header
// (target, start address, count) and drives the shared RAM write port.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for SYNC_BYTE, other bytes dropped
// ST_TGT  | expecting TARGET byte
// ST_A2   | expecting ADDR[23:16]
// ST_A1   | expecting ADDR[15:8]
// ST_A0   | expecting ADDR[7:0]
// ST_C2   | expecting COUNT[23:16]
// ST_C1   | expecting COUNT[15:8]
// ST_C0   | expecting COUNT[7:0]
// ST_DATA | payload bytes, one write per transfer
// ST_DONE | one-cycle end-of-frame, din_ready low
module sprite_ram_loader #(
  parameter int          ADDR_W     = 19,
  parameter int          CHAR_DEPTH = 6613,
  parameter int          MAP_DEPTH  = 76801,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              char_we,
  output logic              map_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_TGT, ST_A2, ST_A1, ST_A0, ST_C2, ST_C1, ST_C0, ST_DATA, ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] CHAR_LIM = ADDR_W'(CHAR_DEPTH);
  localparam logic [ADDR_W-1:0] MAP_LIM  = ADDR_W'(MAP_DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, cnt;
  logic [ADDR_W-1:0] ptr_shift, cnt_shift;
  logic              tgt_map, tgt_bad, oob;
  logic              xfer, wr_ok;

  assign din_ready = Reset && (state != ST_DONE);
  assign xfer      = din_valid && din_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Header fields are 24 bits on the wire; shifting into ADDR_W bits keeps the low bits.
  assign ptr_shift = {ptr[ADDR_W-9:0], din};
  assign cnt_shift = {cnt[ADDR_W-9:0], din};

  // Once a frame has run past its limit, wrapping back to low addresses must stay disabled.
  assign wr_ok = !tgt_bad && !oob && (ptr < (tgt_map ? MAP_LIM : CHAR_LIM));

  always_ff @(posedge Clk) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_DONE) begin
      state_nxt = ST_IDLE;
    end else if (xfer) begin
      case (state)
        ST_IDLE: if (din == SYNC_BYTE) state_nxt = ST_TGT;
        ST_TGT:  state_nxt = ST_A2;
        ST_A2:   state_nxt = ST_A1;
        ST_A1:   state_nxt = ST_A0;
        ST_A0:   state_nxt = ST_C2;
        ST_C2:   state_nxt = ST_C1;
        ST_C1:   state_nxt = ST_C0;
        ST_C0:   state_nxt = (cnt_shift == '0) ? ST_DONE : ST_DATA;
        ST_DATA: if (cnt == ADDR_W'(1)) state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ptr     <= '0;
      cnt     <= '0;
      tgt_map <= 1'b0;
      tgt_bad <= 1'b0;
      oob     <= 1'b0;
      err     <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      char_we <= 1'b0;
      map_we  <= 1'b0;
    end else begin
      char_we <= 1'b0;
      map_we  <= 1'b0;
      if (xfer) begin
        case (state)
          ST_IDLE: begin
            if (din == SYNC_BYTE) begin
              err <= 1'b0;
              oob <= 1'b0;
              ptr <= '0;
              cnt <= '0;
            end
          end
          ST_TGT: begin
            tgt_map <= (din == 8'd1);
            tgt_bad <= (din > 8'd1);
            if (din > 8'd1) err <= 1'b1;
          end
          ST_A2, ST_A1, ST_A0: ptr <= ptr_shift;
          ST_C2, ST_C1, ST_C0: cnt <= cnt_shift;
          ST_DATA: begin
            cnt     <= cnt - ADDR_W'(1);
            ptr     <= ptr + ADDR_W'(1);
            wr_addr <= ptr;
            wr_data <= din;
            if (wr_ok) begin
              char_we <= !tgt_map;
              map_we  <= tgt_map;
            end else begin
              err <= 1'b1;
              oob <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: directed frames plus randomized
// frames checked against a per-byte write model derived from the frame rules.
module tb_sprite_ram_loader;

  localparam int          ADDR_W     = 19;
  localparam int          CHAR_DEPTH = 6613;
  localparam int          MAP_DEPTH  = 76801;
  localparam logic [7:0]  SYNC       = 8'hA5;
  localparam int unsigned AMASK      = (1 << ADDR_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [7:0]        din;
  logic              din_valid;
  logic              din_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              char_we, map_we, busy, done, err;

  sprite_ram_loader #(
    .ADDR_W(ADDR_W), .CHAR_DEPTH(CHAR_DEPTH), .MAP_DEPTH(MAP_DEPTH), .SYNC_BYTE(SYNC)
  ) dut (
    .Clk(Clk), .Reset(Reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .char_we(char_we), .map_we(map_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int both_cnt = 0;
  logic [7:0] pay [16];

  always @(posedge Clk) begin
    if (char_we || map_we) we_cnt <= we_cnt + 1;
    if (char_we && map_we) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a byte and hold it until one transfer has happened; returns on the
  // negedge following the transfer edge.
  task automatic send(input logic [7:0] b);
    int g = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && g < 20) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 20) check("ready_timeout", 32'(din_ready), 32'd1);
    @(negedge Clk);
    din_valid = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
  endtask

  task automatic frame(input logic [7:0] tgt, input logic [23:0] addr24,
                       input logic [23:0] cnt24, input bit gap);
    int unsigned a, n, lim, p;
    bit badt, oob, exp_err, exp_c, exp_m;
    int we0, exp_w;
    logic [7:0] hdr [7];
    a    = int'(addr24) & AMASK;
    n    = int'(cnt24) & AMASK;
    lim  = (tgt == 8'd1) ? MAP_DEPTH : CHAR_DEPTH;
    badt = (tgt > 8'd1);
    hdr  = '{tgt, addr24[23:16], addr24[15:8], addr24[7:0],
             cnt24[23:16], cnt24[15:8], cnt24[7:0]};
    we0   = we_cnt;
    exp_w = 0;
    send(SYNC);
    check("sync_err_clear", 32'(err), 32'd0);
    check("sync_busy", 32'(busy), 32'd1);
    if (gap) @(negedge Clk);
    for (int i = 0; i < 7; i++) begin
      send(hdr[i]);
      if (gap && !(i == 6 && n == 0)) @(negedge Clk);
    end
    exp_err = badt;
    oob = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      p = (a + i) & AMASK;
      if (p >= lim) oob = 1'b1;
      send(pay[i]);
      exp_c = !badt && !oob && (tgt == 8'd0);
      exp_m = !badt && !oob && (tgt == 8'd1);
      if (exp_c || exp_m) exp_w++;
      if (badt || oob) exp_err = 1'b1;
      check("char_we", 32'(char_we), 32'(exp_c));
      check("map_we", 32'(map_we), 32'(exp_m));
      if (exp_c || exp_m) begin
        check("wr_addr", 32'(wr_addr), p);
        check("wr_data", 32'(wr_data), 32'(pay[i]));
      end
      if (gap && i != n - 1) begin
        @(negedge Clk);
        check("we_idle_gap", 32'(char_we | map_we), 32'd0);
      end
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_not_ready", 32'(din_ready), 32'd0);
    @(negedge Clk);
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(din_ready), 32'd1);
    check("frame_err", 32'(err), 32'(exp_err));
    check("frame_writes", 32'(we_cnt - we0), 32'(exp_w));
    check("one_hot_we", 32'(both_cnt), 32'd0);
  endtask

  initial begin
    int we0, r, n, lim;
    logic [7:0] tg, gb;
    logic [23:0] ad;
    Reset = 1'b0;
    din_valid = 1'b0;
    din = 8'h00;
    repeat (2) @(negedge Clk);
    check("rst_char_we", 32'(char_we), 32'd0);
    check("rst_map_we", 32'(map_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Basic char frame, back to back
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    frame(8'd0, 24'h000010, 24'h000003, 1'b0);

    // Map frame straddling the map limit, valid toggling
    pay[0] = 8'h7E; pay[1] = 8'h7F;
    frame(8'd1, 24'h012C00, 24'h000002, 1'b1);

    // Garbage before a valid frame
    we0 = we_cnt;
    send(8'h00); send(8'hFF); send(8'h12);
    @(negedge Clk);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_writes", 32'(we_cnt - we0), 32'd0);
    fill_rand();
    frame(8'd0, 24'h000005, 24'h000002, 1'b0);

    // Bad target: payload consumed, err sticky until next sync
    fill_rand();
    frame(8'd2, 24'h000010, 24'h000002, 1'b0);
    send(8'h00);
    check("err_sticky", 32'(err), 32'd1);
    fill_rand();
    frame(8'd0, 24'h000020, 24'h000001, 1'b0);

    // Zero-length frame
    frame(8'd0, 24'h000064, 24'h000000, 1'b0);

    // Pointer wrap after running off the end stays suppressed
    fill_rand();
    frame(8'd0, 24'h07FFFE, 24'h000004, 1'b0);

    // Upper header bits ignored; count 0x080002 -> 2
    fill_rand();
    frame(8'd1, 24'hF80040, 24'h080002, 1'b1);

    // Reset in the middle of DATA
    fill_rand();
    send(SYNC); send(8'h00); send(8'h00); send(8'h00); send(8'h20);
    send(8'h00); send(8'h00); send(8'h04);
    send(pay[0]);
    check("pre_rst_write", 32'(char_we), 32'd1);
    Reset = 1'b0;
    din = 8'h44;
    din_valid = 1'b1;
    @(negedge Clk);
    check("mid_rst_char_we", 32'(char_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(din_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    we0 = we_cnt;
    Reset = 1'b1;
    din_valid = 1'b0;
    send(8'h22); send(8'h33);
    @(negedge Clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_writes", 32'(we_cnt - we0), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      r  = $urandom_range(0, 9);
      tg = (r == 0) ? 8'($urandom_range(2, 255)) : 8'(r % 2);
      lim = (tg == 8'd1) ? MAP_DEPTH : CHAR_DEPTH;
      if ($urandom_range(0, 1) == 0) n = lim - $urandom_range(0, 4);
      else                           n = $urandom_range(0, lim - 1);
      ad = {5'($urandom), 19'(n)};
      n  = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) begin
        gb = 8'($urandom);
        if (gb == SYNC) gb = 8'h00;
        send(gb);
      end
      fill_rand();
      frame(tg, ad, {5'($urandom), 19'(n)}, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
